// File: rtl/sys_bus_pkg.sv
// Shared definitions for the system bus decoder: FSM encoding and fixed constants.
// No logic.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bus_state_t;

    localparam int          TMO_DEFAULT = 255;
    localparam logic [31:0] ERR_DATA    = 32'hDEADBEEF;

endpackage

// File: rtl/sys_bus_tmo_cnt.sv
// Slave-ack wait counter; expired flags the WAIT cycle in which the count reaches TMO.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counts only while enabled and saturates at its maximum.
module sys_bus_tmo_cnt #(
    parameter int TMO = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    // The increment taken in this cycle is the one that brings the count to TMO.
    assign expired = enable && (cnt == 16'(TMO - 1));

endmodule

// File: rtl/sys_bus_decoder.sv
// Single-master address decoder fanning one transfer at a time out to SN slave windows.
// Latency: strobe -> slave strobe 1 cycle; s_ack 2+k cycles after the master strobe (k = slave ack delay).
// Backpressure: none; master strobes arriving while a transfer is in flight are dropped.
module sys_bus_decoder
    import sys_bus_pkg::*;
#(
    parameter int SN  = 8,
    parameter int SW  = 20,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [31:0]      s_addr,
    input  logic [31:0]      s_wdata,
    input  logic             s_wen,
    input  logic             s_ren,
    output logic [31:0]      s_rdata,
    output logic             s_ack,
    output logic             s_err,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    output logic [SN-1:0]    m_wen,
    output logic [SN-1:0]    m_ren,
    input  logic [SN*32-1:0] m_rdata,
    input  logic [SN-1:0]    m_ack,
    input  logic [SN-1:0]    m_err
);

    bus_state_t  state;
    logic [3:0]  idx_q;
    logic        wr_q;
    logic [3:0]  idx_in;
    logic        bad_dec;
    logic [31:0] sel_rdata;
    logic        sel_ack;
    logic        sel_err;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    assign idx_in  = s_addr[SW+3:SW];
    assign bad_dec = ({1'b0, idx_in} >= 5'(SN)) || (s_addr[31:SW+4] != '0);

    // Only the selected slave's response is visible; all other ack/err bits are ignored.
    always_comb begin
        sel_rdata = '0;
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < SN; i++) begin
            if (idx_q == 4'(i)) begin
                sel_rdata = m_rdata[i*32 +: 32];
                sel_ack   = m_ack[i];
                sel_err   = m_err[i];
            end
        end
    end

    assign tmo_clear  = (state != ST_WAIT);
    assign tmo_enable = (state == ST_WAIT);

    sys_bus_tmo_cnt #(.TMO(TMO)) u_tmo_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wen   <= '0;
            m_ren   <= '0;
            s_ack   <= 1'b0;
            s_err   <= 1'b0;
            s_rdata <= '0;
        end else begin
            m_wen <= '0;
            m_ren <= '0;
            s_ack <= 1'b0;
            s_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_wen || s_ren) begin
                        m_addr  <= s_addr;
                        m_wdata <= s_wdata;
                        wr_q    <= s_wen;
                        idx_q   <= idx_in;
                        if (bad_dec) begin
                            state   <= ST_RESP;
                            s_ack   <= 1'b1;
                            s_err   <= 1'b1;
                            s_rdata <= '0;
                        end else begin
                            state <= ST_ISSUE;
                            // Write wins when both strobes are raised together.
                            if (s_wen) m_wen <= SN'(1) << idx_in;
                            else       m_ren <= SN'(1) << idx_in;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (sel_ack) begin
                        state   <= ST_RESP;
                        s_ack   <= 1'b1;
                        s_err   <= sel_err;
                        s_rdata <= wr_q ? 32'd0 : sel_rdata;
                    end else if (state == ST_ISSUE) begin
                        state <= ST_WAIT;
                    end else if (tmo_expired) begin
                        state   <= ST_RESP;
                        s_ack   <= 1'b1;
                        s_err   <= 1'b1;
                        s_rdata <= ERR_DATA;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
